fetch_instr_queue: RTL and testbench

// - Fetch-side instruction queue between the IF stages and decode; consumer end of the

---
 rtl/fetch_instr_queue.sv | 86 ++++++++
 tb/tb_fetch_instr_queue.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_instr_queue.sv
// Fetch-side instruction queue sitting between the IF stages and decode.
// Packets are buffered in arrival order in a circular buffer and the head is
// presented first-word-fall-through. IF1 is stalled SLACK entries early so that
// packets already in flight still find room. A redirect (flush) or reset empties
// the queue without clearing the entry storage.
module fetch_instr_queue #(
    parameter int DEPTH = 8,
    parameter int SLACK = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [31:0]                in_pc,
    input  logic [31:0]                in_instr,
    input  logic [7:0]                 in_ecode,
    input  logic                       flush,
    input  logic                       out_ready,
    output logic                       out_valid,
    output logic [31:0]                out_pc,
    output logic [31:0]                out_instr,
    output logic [7:0]                 out_ecode,
    output logic                       stall_full_instr,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [31:0]   r_pcMem    [DEPTH];
    logic [31:0]   r_instrMem [DEPTH];
    logic [7:0]    r_ecodeMem [DEPTH];
    logic [AW-1:0] r_head;
    logic [AW-1:0] r_tail;
    logic [CW-1:0] r_count;

    logic          w_pop;
    logic          w_push;
    logic          w_clear;

    // Handshake decode: a pop in the same cycle frees a slot for a push when full
    always_comb begin
        w_clear  = rst | flush;
        w_pop    = (r_count != '0) & out_ready;
        w_push   = in_valid & ((r_count < CW'(DEPTH)) | w_pop);
        overflow = in_valid & ~w_push & ~w_clear;
    end

    // Head entry and status are driven straight from registers, never from in_*
    always_comb begin
        out_valid        = (r_count != '0);
        out_pc           = r_pcMem[r_head];
        out_instr        = r_instrMem[r_head];
        out_ecode        = r_ecodeMem[r_head];
        stall_full_instr = (r_count >= CW'(DEPTH - SLACK));
        count            = r_count;
    end

    // Entry storage: written at the tail on an accepted push, never reset
    always_ff @(posedge clk) begin
        if (w_push && !w_clear) begin
            r_pcMem[r_tail]    <= in_pc;
            r_instrMem[r_tail] <= in_instr;
            r_ecodeMem[r_tail] <= in_ecode;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two; occupancy lives in r_count
    always_ff @(posedge clk) begin
        if (w_clear) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_tail <= r_tail + AW'(1);
            if (w_pop)  r_head <= r_head + AW'(1);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    // A dropped packet can only ever happen against a full queue that is not draining
    always_ff @(posedge clk) begin
        if (!rst) assert (!overflow || ((r_count == CW'(DEPTH)) && !w_pop));
    end

endmodule

// File: tb/tb_fetch_instr_queue.sv
// Self-checking bench for fetch_instr_queue. A packet queue model tracks what the
// queue should hold; each scenario task drives stimulus and compares inline.
module tb_fetch_instr_queue;

    localparam int DEPTH = 8;
    localparam int SLACK = 2;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [7:0]  ecode;
    } pkt_t;

    logic        clk;
    logic        rst;
    logic        inValid;
    logic [31:0] inPc;
    logic [31:0] inInstr;
    logic [7:0]  inEcode;
    logic        flush;
    logic        outReady;
    logic        outValid;
    logic [31:0] outPc;
    logic [31:0] outInstr;
    logic [7:0]  outEcode;
    logic        stallFull;
    logic [3:0]  count;
    logic        overflow;

    pkt_t modelQ[$];
    int   total;
    int   bad;
    logic obsOvf;
    logic expOvf;

    fetch_instr_queue #(.DEPTH(DEPTH), .SLACK(SLACK)) dut (
        .clk              (clk),
        .rst              (rst),
        .in_valid         (inValid),
        .in_pc            (inPc),
        .in_instr         (inInstr),
        .in_ecode         (inEcode),
        .flush            (flush),
        .out_ready        (outReady),
        .out_valid        (outValid),
        .out_pc           (outPc),
        .out_instr        (outInstr),
        .out_ecode        (outEcode),
        .stall_full_instr (stallFull),
        .count            (count),
        .overflow         (overflow)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drives one cycle of inputs and advances the queue model across the clock edge
    task automatic applyStimulus(input logic r, input logic fl, input logic v, input logic rdy,
                                 input logic [31:0] pc, input logic [31:0] instr,
                                 input logic [7:0] ec);
        int   n;
        logic doPop;
        logic doPush;
        pkt_t p;
        rst = r; flush = fl; inValid = v; outReady = rdy;
        inPc = pc; inInstr = instr; inEcode = ec;
        #2;
        obsOvf = overflow;
        n      = modelQ.size();
        doPop  = (n > 0) && rdy;
        doPush = v && ((n < DEPTH) || doPop);
        expOvf = v && !doPush && !fl && !r;
        @(posedge clk);
        if (r || fl) begin
            modelQ.delete();
        end else begin
            if (doPop) void'(modelQ.pop_front());
            if (doPush) begin
                p.pc = pc; p.instr = instr; p.ecode = ec;
                modelQ.push_back(p);
            end
        end
        #1;
        rst = 1'b0; flush = 1'b0; inValid = 1'b0; outReady = 1'b0;
    endtask

    task automatic test_reset();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 8'h0);
        total++;
        if (count !== 4'd0) begin bad++; $display("[TB] FAIL reset_count got=%0d want=0", count); end
        total++;
        if (outValid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid got=%b want=0", outValid); end
        total++;
        if (stallFull !== 1'b0) begin bad++; $display("[TB] FAIL reset_stall got=%b want=0", stallFull); end
        total++;
        if (overflow !== 1'b0) begin bad++; $display("[TB] FAIL reset_ovf got=%b want=0", overflow); end
    endtask

    task automatic test_fill();
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h1c000000 + 32'(4 * i), $urandom, {1'b0, 7'($urandom)});
            total++;
            if (obsOvf !== 1'b0) begin bad++; $display("[TB] FAIL fill_ovf i=%0d got=%b want=0", i, obsOvf); end
            total++;
            if (count !== 4'(i + 1)) begin bad++; $display("[TB] FAIL fill_count i=%0d got=%0d want=%0d", i, count, i + 1); end
            total++;
            if (stallFull !== ((i + 1) >= DEPTH - SLACK)) begin
                bad++; $display("[TB] FAIL fill_stall i=%0d got=%b want=%b", i, stallFull, ((i + 1) >= DEPTH - SLACK));
            end
        end
        total++;
        if (outPc !== 32'h1c000000) begin bad++; $display("[TB] FAIL fill_head got=%h want=1c000000", outPc); end
    endtask

    task automatic test_overflow();
        logic [31:0] prevPc;
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h1c000020, $urandom, 8'h00);
        total++;
        if (obsOvf !== 1'b1) begin bad++; $display("[TB] FAIL ovf_pulse got=%b want=1", obsOvf); end
        total++;
        if (count !== 4'd8) begin bad++; $display("[TB] FAIL ovf_count got=%0d want=8", count); end
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 8'h0);
        total++;
        if (obsOvf !== 1'b0) begin bad++; $display("[TB] FAIL ovf_oneshot got=%b want=0", obsOvf); end
        prevPc = outPc;
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 32'h1c000020, $urandom, 8'h00);
        total++;
        if (obsOvf !== 1'b0) begin bad++; $display("[TB] FAIL full_pushpop_ovf got=%b want=0", obsOvf); end
        total++;
        if (count !== 4'd8) begin bad++; $display("[TB] FAIL full_pushpop_count got=%0d want=8", count); end
        total++;
        if (outPc !== prevPc + 32'd4) begin bad++; $display("[TB] FAIL full_pushpop_pc got=%h want=%h", outPc, prevPc + 32'd4); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] prevPc;
        logic [31:0] nextPc;
        nextPc = 32'h1c000024;
        for (int i = 0; i < 12; i++) begin
            prevPc = outPc;
            applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, nextPc, $urandom, {1'b0, 7'($urandom)});
            nextPc = nextPc + 32'd4;
            total++;
            if (count !== 4'd8) begin bad++; $display("[TB] FAIL b2b_count i=%0d got=%0d want=8", i, count); end
            total++;
            if (outPc !== prevPc + 32'd4 || outPc !== modelQ[0].pc) begin
                bad++; $display("[TB] FAIL b2b_pc i=%0d got=%h want=%h", i, outPc, modelQ[0].pc);
            end
            total++;
            if (outInstr !== modelQ[0].instr) begin
                bad++; $display("[TB] FAIL b2b_instr i=%0d got=%h want=%h", i, outInstr, modelQ[0].instr);
            end
        end
    endtask

    task automatic test_flush();
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 8'h0);
        for (int i = 0; i < 5; i++)
            applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h1c000040 + 32'(4 * i), $urandom, 8'h00);
        total++;
        if (count !== 4'd5) begin bad++; $display("[TB] FAIL flush_pre_count got=%0d want=5", count); end
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 32'h1c000060, $urandom, 8'h00);
        total++;
        if (obsOvf !== 1'b0) begin bad++; $display("[TB] FAIL flush_ovf got=%b want=0", obsOvf); end
        total++;
        if (count !== 4'd0) begin bad++; $display("[TB] FAIL flush_count got=%0d want=0", count); end
        total++;
        if (outValid !== 1'b0) begin bad++; $display("[TB] FAIL flush_valid got=%b want=0", outValid); end
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h1c000100, 32'hdeadbeef, 8'h00);
        total++;
        if (outValid !== 1'b1 || outPc !== 32'h1c000100) begin
            bad++; $display("[TB] FAIL flush_refill got=%b/%h want=1/1c000100", outValid, outPc);
        end
        total++;
        if (count !== 4'd1) begin bad++; $display("[TB] FAIL flush_refill_count got=%0d want=1", count); end
    endtask

    task automatic test_ecode();
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 8'h0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h1c000200, $urandom, 8'h00);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h1c000204, $urandom, 8'b1_000_1000);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h1c000208, $urandom, 8'h00);
        for (int i = 0; i < 3; i++) begin
            total++;
            if (outValid !== 1'b1 || outPc !== 32'h1c000200 + 32'(4 * i) || outInstr !== modelQ[0].instr) begin
                bad++; $display("[TB] FAIL ecode_order i=%0d got=%h want=%h", i, outPc, 32'h1c000200 + 32'(4 * i));
            end
            total++;
            if (outEcode !== ((i == 1) ? 8'h88 : 8'h00)) begin
                bad++; $display("[TB] FAIL ecode_value i=%0d got=%h want=%h", i, outEcode, ((i == 1) ? 8'h88 : 8'h00));
            end
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 8'h0);
        end
        total++;
        if (outValid !== 1'b0) begin bad++; $display("[TB] FAIL ecode_drained got=%b want=0", outValid); end
    endtask

    task automatic test_rst_midstream();
        for (int i = 0; i < 4; i++)
            applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h1c000300 + 32'(4 * i), $urandom, 8'h00);
        total++;
        if (count !== 4'd4) begin bad++; $display("[TB] FAIL rst_pre_count got=%0d want=4", count); end
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 32'h1c000310, $urandom, 8'h00);
        total++;
        if (obsOvf !== 1'b0) begin bad++; $display("[TB] FAIL rst_mid_ovf got=%b want=0", obsOvf); end
        total++;
        if (count !== 4'd0 || outValid !== 1'b0 || stallFull !== 1'b0) begin
            bad++; $display("[TB] FAIL rst_mid got=cnt%0d/v%b/s%b want=cnt0/v0/s0", count, outValid, stallFull);
        end
    endtask

    task automatic test_random();
        logic        v;
        logic        rdy;
        logic        fl;
        logic [31:0] pc;
        pc = 32'h1c001000;
        for (int i = 0; i < 400; i++) begin
            v   = ($urandom_range(0, 3) != 0);
            rdy = ($urandom_range(0, 2) != 0);
            fl  = ($urandom_range(0, 31) == 0);
            applyStimulus(1'b0, fl, v, rdy, pc, $urandom, 8'($urandom));
            if (v) pc = pc + 32'd4;
            total++;
            if (obsOvf !== expOvf) begin bad++; $display("[TB] FAIL rnd_ovf i=%0d got=%b want=%b", i, obsOvf, expOvf); end
            total++;
            if (count !== 4'(modelQ.size())) begin bad++; $display("[TB] FAIL rnd_count i=%0d got=%0d want=%0d", i, count, modelQ.size()); end
            total++;
            if (stallFull !== (modelQ.size() >= DEPTH - SLACK)) begin
                bad++; $display("[TB] FAIL rnd_stall i=%0d got=%b want=%b", i, stallFull, (modelQ.size() >= DEPTH - SLACK));
            end
            total++;
            if (outValid !== (modelQ.size() != 0)) begin
                bad++; $display("[TB] FAIL rnd_valid i=%0d got=%b want=%b", i, outValid, (modelQ.size() != 0));
            end
            if (modelQ.size() != 0) begin
                total++;
                if (outPc !== modelQ[0].pc || outInstr !== modelQ[0].instr || outEcode !== modelQ[0].ecode) begin
                    bad++; $display("[TB] FAIL rnd_head i=%0d got=%h/%h/%h want=%h/%h/%h", i, outPc, outInstr, outEcode,
                                    modelQ[0].pc, modelQ[0].instr, modelQ[0].ecode);
                end
            end
        end
    endtask

    // Bounds the run so a wedged simulation still reports and ends
    initial begin
        #500000;
        $display("[TB] FAIL watchdog got=timeout want=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Scenario sequence
    initial begin
        total = 0; bad = 0;
        rst = 1'b1; flush = 1'b0; inValid = 1'b0; outReady = 1'b0;
        inPc = '0; inInstr = '0; inEcode = '0;
        obsOvf = 1'b0; expOvf = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_fill();
        test_overflow();
        test_back_to_back();
        test_flush();
        test_ecode();
        test_rst_midstream();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
